// File: rtl/fib_inst_sequencer_if.sv
// Handshake and instruction bus between a Fibonacci program sequencer and its user.
// The master drives start, n_terms and stall. The slave, which is the sequencer, drives
// the instruction stream, the status flags and the shadow result.
interface fib_inst_sequencer_if #(
    parameter int COUNT_W = 8,
    parameter int DATA_W  = 32
);
    logic               start;
    logic [COUNT_W-1:0] n_terms;
    logic               stall;
    logic [31:0]        inst;
    logic               inst_valid;
    logic               busy;
    logic               done;
    logic [COUNT_W-1:0] term_idx;
    logic [DATA_W-1:0]  exp_result;

    modport master (
        output start, n_terms, stall,
        input  inst, inst_valid, busy, done, term_idx, exp_result
    );

    modport slave (
        input  start, n_terms, stall,
        output inst, inst_valid, busy, done, term_idx, exp_result
    );
endinterface

// File: rtl/fib_inst_sequencer.sv
// Fibonacci instruction generator for a MIPS-style CPU.
// It emits two ADDIs that seed REG_A and REG_B, then n_terms ADDs whose destination
// alternates between the two registers. A shadow copy of the sums it predicts is
// kept so the final register value can be checked.
//
// state  | meaning
// IDLE   | waiting for start; outputs NOP
// LD_A   | ADDI REG_A is on the bus
// LD_B   | ADDI REG_B is on the bus
// LOOP   | ADD for term term_idx is on the bus
// DONE   | program finished; done held until the next start
module fib_inst_sequencer #(
    parameter int COUNT_W = 8,
    parameter int DATA_W  = 32,
    parameter int REG_A   = 1,
    parameter int REG_B   = 2,
    parameter int INIT_A  = 1,
    parameter int INIT_B  = 1
) (
    input  logic              clk,
    input  logic              rst,
    fib_inst_sequencer_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_LD_A, S_LD_B, S_LOOP, S_DONE} state_t;

    localparam logic [4:0]        RA       = 5'(REG_A);
    localparam logic [4:0]        RB       = 5'(REG_B);
    localparam logic [15:0]       IMM_A    = 16'(INIT_A);
    localparam logic [15:0]       IMM_B    = 16'(INIT_B);
    localparam logic [31:0]       NOP      = 32'h0;
    localparam logic [31:0]       ADDI_A   = {6'b001000, 5'd0, RA, IMM_A};
    localparam logic [31:0]       ADDI_B   = {6'b001000, 5'd0, RB, IMM_B};
    localparam logic [31:0]       ADD_TO_A = {6'b000000, RA, RB, RA, 5'd0, 6'b100000};
    localparam logic [31:0]       ADD_TO_B = {6'b000000, RA, RB, RB, 5'd0, 6'b100000};
    localparam logic [DATA_W-1:0] SEXT_A   = DATA_W'($signed(IMM_A));
    localparam logic [DATA_W-1:0] SEXT_B   = DATA_W'($signed(IMM_B));

    state_t             r_state, w_state;
    logic [COUNT_W-1:0] r_rem, w_rem;
    logic [COUNT_W-1:0] r_idx, w_idx;
    logic [DATA_W-1:0]  r_a, w_a;
    logic [DATA_W-1:0]  r_b, w_b;
    logic [DATA_W-1:0]  r_res, w_res;
    logic [31:0]        r_inst, w_inst;
    logic               r_valid, w_valid;
    logic               r_busy, w_busy;
    logic               r_done, w_done;
    logic [DATA_W-1:0]  w_sum;

    // Next state and next registered outputs.
    // r_rem counts the ADDs still to be issued after the one on the bus.
    // When stall is high, every register keeps its value and the next cycle shows a NOP.
    always_comb begin
        w_state = r_state;
        w_rem   = r_rem;
        w_idx   = r_idx;
        w_a     = r_a;
        w_b     = r_b;
        w_res   = r_res;
        w_inst  = NOP;
        w_valid = 1'b0;
        w_busy  = r_busy;
        w_done  = r_done;
        w_sum   = r_a + r_b;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_state = S_LD_A;
                    w_rem   = bus.n_terms;
                    w_busy  = 1'b1;
                    w_done  = 1'b0;
                    w_inst  = ADDI_A;
                    w_valid = 1'b1;
                end
            end
            S_LD_A: begin
                if (!bus.stall) begin
                    w_state = S_LD_B;
                    w_inst  = ADDI_B;
                    w_valid = 1'b1;
                    w_a     = SEXT_A;
                    w_b     = SEXT_B;
                end
            end
            S_LD_B: begin
                if (!bus.stall) begin
                    if (r_rem != '0) begin
                        w_state = S_LOOP;
                        w_rem   = r_rem - 1'b1;
                        w_idx   = '0;
                        w_inst  = ADD_TO_A;
                        w_valid = 1'b1;
                        w_a     = w_sum;
                        w_res   = w_sum;
                    end else begin
                        w_state = S_DONE;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                    end
                end
            end
            S_LOOP: begin
                if (!bus.stall) begin
                    if (r_rem == '0) begin
                        w_state = S_DONE;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                    end else begin
                        w_rem   = r_rem - 1'b1;
                        w_idx   = r_idx + 1'b1;
                        w_valid = 1'b1;
                        w_res   = w_sum;
                        if (r_idx[0]) begin
                            w_inst = ADD_TO_A;
                            w_a    = w_sum;
                        end else begin
                            w_inst = ADD_TO_B;
                            w_b    = w_sum;
                        end
                    end
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    // State register and registered outputs, with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_inst  <= NOP;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_rem   <= w_rem;
            r_idx   <= w_idx;
            r_a     <= w_a;
            r_b     <= w_b;
            r_res   <= w_res;
            r_inst  <= w_inst;
            r_valid <= w_valid;
            r_busy  <= w_busy;
            r_done  <= w_done;
        end
    end

    assign bus.inst       = r_inst;
    assign bus.inst_valid = r_valid;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.term_idx   = r_idx;
    assign bus.exp_result = r_res;
endmodule
